// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK  = 7'h7F;
    localparam seg7_t SEG_ZERO   = 7'b1000000;
    localparam int    NUM_DIGITS = 3;
    localparam int    CNT_W      = 17;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef struct packed {
        seg7_t upper;
        seg7_t middle;
        seg7_t lower;
    } seg_triple_t;

    function automatic seg7_t digit_pat(seg_triple_t t, logic [1:0] idx);
        case (idx)
            2'd0:    return t.lower;
            2'd1:    return t.middle;
            default: return t.upper;
        endcase
    endfunction

    // Bit i set means digit i is suppressed; the ones digit always shows.
    function automatic logic [2:0] lz_mask(seg_triple_t t, logic lz_en);
        logic up_blank;
        logic mid_blank;
        up_blank  = lz_en && (t.upper == SEG_ZERO);
        mid_blank = up_blank && (t.middle == SEG_ZERO);
        return {up_blank, mid_blank, 1'b0};
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Pattern-triple update channel: three active-low digits with valid/ready.
interface seg_scan_mux_if;
    import seg_pkg::*;

    seg7_t seg_upper;
    seg7_t seg_middle;
    seg7_t seg_lower;
    logic  upd_valid;
    logic  upd_ready;

    modport master (
        output seg_upper, seg_middle, seg_lower, upd_valid,
        input  upd_ready
    );

    modport slave (
        input  seg_upper, seg_middle, seg_lower, upd_valid,
        output upd_ready
    );

endinterface

// File: rtl/seg_scan_mux_scan_timer.sv
// Slot counter and GUARD/DRIVE/digit sequencing. Outputs describe the state
// being entered on the next edge so the caller can register its drive directly.
module scan_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx,
    output logic       drive,
    output logic       frame_start
);

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GUARD;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            GUARD: begin
                if (cnt_q == G_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == D_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    assign idx         = idx_d;
    assign drive       = (state_d == DRIVE);
    // Last guard cycle before the ones digit: the edge that swaps buffers.
    assign frame_start = (state_q == GUARD) && (idx_q == 2'd0) && (cnt_q == G_LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered 3-digit scan driver for a 4-anode common-anode display,
// with per-slot blanking guard and optional leading-zero suppression.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave upd,
    input  logic          lz_en,
    input  logic          disp_en,
    output logic [3:0]    an,
    output seg7_t         seg,
    output logic          dp
);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
            $error("seg_scan_mux: need 1 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    logic [1:0] idx;
    logic       drive;
    logic       frame_start;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .drive      (drive),
        .frame_start(frame_start)
    );

    seg_triple_t act_q, act_d;
    seg_triple_t pbuf_q, pbuf_d;
    logic        pnd_q, pnd_d;
    logic [3:0]  an_q, an_d;
    seg7_t       seg_q, seg_d;
    logic [2:0]  blk;
    logic        capture;

    assign upd.upd_ready = ~pnd_q;
    assign capture       = upd.upd_valid & ~pnd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= {SEG_BLANK, SEG_BLANK, SEG_BLANK};
            pbuf_q <= {SEG_BLANK, SEG_BLANK, SEG_BLANK};
            pnd_q  <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
        end else begin
            act_q  <= act_d;
            pbuf_q <= pbuf_d;
            pnd_q  <= pnd_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    // Swap and capture never collide: capture needs pending clear, swap needs it set.
    always_comb begin
        act_d  = act_q;
        pbuf_d = pbuf_q;
        pnd_d  = pnd_q;
        if (frame_start && pnd_q) begin
            act_d = pbuf_q;
            pnd_d = 1'b0;
        end
        if (capture) begin
            pbuf_d = {upd.seg_upper, upd.seg_middle, upd.seg_lower};
            pnd_d  = 1'b1;
        end
    end

    assign blk = lz_mask(act_d, lz_en);

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_an
        assign an_d[d] = ~(disp_en && drive && (idx == 2'(d)) && !blk[d]);
    end
    assign an_d[3] = 1'b1;

    always_comb begin
        seg_d = SEG_BLANK;
        if (disp_en && drive && !blk[idx]) seg_d = digit_pat(act_d, idx);
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule
